lsu_mem_initiator: RTL and testbench

- Load/store initiator that sits between the core's execute stage and the word-wide data memory (64 x 32-bit).
- The memory writes synchronously and reads combinationally, and it has no byte enables.
- This block converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned memory accesses.
- Sub-word stores are done as read-modify-write. Alignment, funct3 and address range are checked, and loaded data is sign- or zero-extended.

---
 rtl/lsu_mem_initiator.sv | 189 ++++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// RV32I load/store initiator for a word-wide, byte-enable-free data memory.
// Sub-word stores are read-modify-write; loads are lane-selected and extended.
module lsu_mem_initiator #(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        MemWrite,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWriteData,
  input  logic [31:0] MemReadData
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  localparam logic [1:0] ErrOk        = 2'b00;
  localparam logic [1:0] ErrMisalign  = 2'b01;
  localparam logic [1:0] ErrIllegal   = 2'b10;
  localparam logic [1:0] ErrRange     = 2'b11;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]  resp_err_q, resp_err_d;

  logic        illegal, misaligned, out_of_range;
  logic [1:0]  req_err;

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] offs,
                                              input logic [2:0] funct3);
    logic [7:0]  b;
    logic [15:0] h;
    case (offs)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = offs[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [1:0] offs,
                                              input logic half, input logic [31:0] wdata);
    logic [31:0] w;
    w = old;
    if (half) begin
      if (offs[1]) w[31:16] = wdata[15:0];
      else         w[15:0]  = wdata[15:0];
    end else begin
      case (offs)
        2'd0:    w[7:0]   = wdata[7:0];
        2'd1:    w[15:8]  = wdata[7:0];
        2'd2:    w[23:16] = wdata[7:0];
        default: w[31:24] = wdata[7:0];
      endcase
    end
    return w;
  endfunction

  // Request classification; illegal funct3 outranks misalignment, which outranks range.
  always_comb begin
    if (req_write) illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    else           illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = ({2'b00, req_addr[31:2]} >= MEM_WORDS);
    if (illegal)           req_err = ErrIllegal;
    else if (misaligned)   req_err = ErrMisalign;
    else if (out_of_range) req_err = ErrRange;
    else                   req_err = ErrOk;
  end

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_write_d  = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (req_err != ErrOk) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'b0;
            resp_err_d   = req_err;
            state_d      = StResp;
          end else if (req_write && (req_funct3 == 3'b010)) begin
            mem_write_d = 1'b1;
            mem_wdata_d = req_wdata;
            state_d     = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (write_q) begin
          mem_write_d = 1'b1;
          mem_wdata_d = store_merge(MemReadData, addr_q[1:0], funct3_q[0], wdata_q);
          state_d     = StWrite;
        end else begin
          resp_valid_d = 1'b1;
          resp_rdata_d = load_extend(MemReadData, addr_q[1:0], funct3_q);
          resp_err_d   = ErrOk;
          state_d      = StResp;
        end
      end
      StWrite: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'b0;
        resp_err_d   = ErrOk;
        state_d      = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      write_q      <= 1'b0;
      funct3_q     <= 3'b0;
      addr_q       <= 32'b0;
      wdata_q      <= 32'b0;
      mem_write_q  <= 1'b0;
      mem_wdata_q  <= 32'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'b0;
      resp_err_q   <= 2'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_write_q  <= mem_write_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign MemWrite     = mem_write_q;
  assign MemAddr      = {addr_q[31:2], 2'b00};
  assign MemWriteData = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: byte-level reference model of loads/stores, a per-cycle
// compare process, directed literal cases and randomized traffic.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        MemWrite;
  logic [31:0] MemAddr, MemWriteData, MemReadData;

  lsu_mem_initiator #(.MEM_WORDS(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .MemWrite    (MemWrite),
    .MemAddr     (MemAddr),
    .MemWriteData(MemWriteData),
    .MemReadData (MemReadData)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Attached memory: combinational read, synchronous write.
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        load_mem;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h8899AABB : (32'h9E3779B9 * (i + 1)) ^ 32'h5A5A0F0F;
  endfunction

  assign MemReadData = mem[MemAddr[7:2]];
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (MemWrite) begin
      mem[MemAddr[7:2]] <= MemWriteData;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Expectations for the transaction in flight, consumed by the compare process.
  logic        chk_en = 1'b0;
  int          acc_cyc = -10, exp_resp_cyc = -5, exp_wr_cyc = -5;
  logic [31:0] exp_maddr, exp_wdata, exp_rdata;
  logic [1:0]  exp_err;
  int          obs_resp_lat, obs_wr_lat;

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, cyc == exp_resp_cyc});
      chk("mem_write", {31'b0, MemWrite}, {31'b0, cyc == exp_wr_cyc});
      chk("req_ready", {31'b0, req_ready}, {31'b0, !(cyc > acc_cyc && cyc <= exp_resp_cyc)});
      if (cyc > acc_cyc && cyc <= exp_resp_cyc) chk("mem_addr", MemAddr, exp_maddr);
      if (cyc == exp_wr_cyc) chk("mem_wdata", MemWriteData, exp_wdata);
      if (cyc == exp_resp_cyc) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", {30'b0, resp_err}, {30'b0, exp_err});
      end
    end
  end

  // Reference: decide error, latency and data from byte-level rules; updates ref_mem on stores.
  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output int wr_off,
                       output logic [31:0] rdata, output logic [1:0] err);
    bit          legal, mis, oor;
    int          size, idx, sh;
    logic [31:0] old, v, mask, nw;
    legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis   = (a % size) != 0;
    oor   = (a / 4) >= 64;
    err   = !legal ? 2'b10 : mis ? 2'b01 : oor ? 2'b11 : 2'b00;
    rdata = 32'b0;
    wr_off = -1;
    exp_wdata = 32'b0;
    if (err != 2'b00) begin
      lat = 1;
      return;
    end
    idx = int'(a / 4);
    sh  = int'(a % 4) * 8;
    old = ref_mem[idx];
    if (!w) begin
      lat = 2;
      v = old >> sh;
      if (size == 1) begin
        v = v & 32'hFF;
        if (f3 == 3'd0 && v[7]) v = v | 32'hFFFFFF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
      end
      rdata = v;
    end else begin
      mask = (size == 4) ? 32'hFFFFFFFF : (size == 2) ? (32'hFFFF << sh) : (32'hFF << sh);
      nw = (old & ~mask) | ((wd << sh) & mask);
      lat = (size == 4) ? 2 : 3;
      wr_off = lat - 1;
      exp_wdata = nw;
      ref_mem[idx] = nw;
    end
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] r, output logic [1:0] e);
    int          lat, wr_off;
    logic [31:0] md;
    logic [1:0]  me;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    model(w, f3, a, wd, lat, wr_off, md, me);
    exp_rdata    = md;
    exp_err      = me;
    exp_maddr    = a & 32'hFFFFFFFC;
    acc_cyc      = cyc;
    exp_resp_cyc = cyc + lat;
    exp_wr_cyc   = (wr_off < 0) ? -5 : cyc + wr_off;
    obs_resp_lat = -1;
    obs_wr_lat   = -1;
    while (cyc < exp_resp_cyc) begin
      @(negedge clk);
      if (resp_valid && obs_resp_lat < 0) obs_resp_lat = cyc - acc_cyc;
      if (MemWrite && obs_wr_lat < 0) obs_wr_lat = cyc - acc_cyc;
      if (cyc < exp_resp_cyc) begin
        // Junk on the request bus while busy must be ignored.
        req_valid  = 1'($urandom_range(0, 1));
        req_write  = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom();
        req_wdata  = $urandom();
      end else begin
        req_valid = 1'b0;
      end
    end
    r = resp_rdata;
    e = resp_err;
  endtask

  logic [31:0] r;
  logic [1:0]  e;

  initial begin
    rst_n = 1'b0;
    load_mem = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_funct3 = 3'b0;
    req_addr = 32'b0;
    req_wdata = 32'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_write", {31'b0, MemWrite}, 32'd0);
    chk("rst_mem_addr", MemAddr, 32'd0);
    chk("rst_mem_wdata", MemWriteData, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {30'b0, resp_err}, 32'd0);
    load_mem = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

    do_req(1'b0, 3'b000, 32'h13, 32'h0, r, e);
    chk("lb_0x13", r, 32'hFFFFFF88);
    chk("lb_lat", 32'(obs_resp_lat), 32'd2);
    chk("lb_no_write", 32'(obs_wr_lat), 32'hFFFFFFFF);
    do_req(1'b0, 3'b101, 32'h12, 32'h0, r, e);
    chk("lhu_0x12", r, 32'h00008899);
    do_req(1'b0, 3'b001, 32'h10, 32'h0, r, e);
    chk("lh_0x10", r, 32'hFFFFAABB);
    do_req(1'b0, 3'b100, 32'h11, 32'h0, r, e);
    chk("lbu_0x11", r, 32'h000000AA);
    do_req(1'b1, 3'b000, 32'h11, 32'h123456CC, r, e);
    chk("sb_wr_lat", 32'(obs_wr_lat), 32'd2);
    chk("sb_resp_lat", 32'(obs_resp_lat), 32'd3);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, r, e);
    chk("lw_after_sb", r, 32'h8899CCBB);
    do_req(1'b1, 3'b010, 32'h10, 32'h12345678, r, e);
    chk("sw_wr_lat", 32'(obs_wr_lat), 32'd1);
    chk("sw_resp_lat", 32'(obs_resp_lat), 32'd2);
    do_req(1'b0, 3'b010, 32'h12, 32'h0, r, e);
    chk("lw_misaligned_err", {30'b0, e}, 32'd1);
    chk("err_lat", 32'(obs_resp_lat), 32'd1);
    do_req(1'b1, 3'b100, 32'h10, 32'hDEADBEEF, r, e);
    chk("st_illegal_err", {30'b0, e}, 32'd2);
    chk("st_illegal_no_write", 32'(obs_wr_lat), 32'hFFFFFFFF);
    do_req(1'b0, 3'b010, 32'h100, 32'h0, r, e);
    chk("lw_range_err", {30'b0, e}, 32'd3);
    chk("lw_range_rdata", r, 32'd0);

    // SH aborted by reset during its read phase.
    @(negedge clk);
    chk_en = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_funct3 = 3'b001;
    req_addr = 32'h10;
    req_wdata = 32'h0000BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_mem_write", {31'b0, MemWrite}, 32'd0);
    chk("abort_mem_addr", MemAddr, 32'd0);
    chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acc_cyc = -10;
    exp_resp_cyc = -5;
    exp_wr_cyc = -5;
    chk_en = 1'b1;
    @(negedge clk);
    chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_mem_unchanged", mem[4], 32'h12345678);

    for (int n = 0; n < 250; n++) begin
      logic        w;
      logic [2:0]  f3;
      logic [31:0] a;
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = $urandom();
      else a = 32'($urandom_range(0, 4 * 64 + 15));
      do_req(w, f3, a, $urandom(), r, e);
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 64; i++) chk("mem_final", mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
